// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared mode constants and index-width helper for the priority encoder
package prio_enc_pkg;
  localparam int PE_FIXED = 0;
  localparam int PE_RR = 1;
  function automatic int idx_width(int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/prio_enc_comb.sv
// prio_enc_comb: combinational N-input encoder returning the highest set index and an any flag
module prio_enc_comb
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) idx = req[i] ? W'(i) : idx;
  end
  assign any = |req;
endmodule

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered fixed/round-robin priority encoder with valid/ready handshake
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  parameter int RR = PE_FIXED,
  localparam int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot
);
  logic [W-1:0] g;
  logic         any;
  logic         load;
  assign in_ready = !out_valid || out_ready;
  assign load = in_valid && in_ready && any;
  generate
    if (RR == PE_RR) begin : g_rr
      logic [W-1:0] ptr, m_idx, u_idx;
      logic [N-1:0] mask;
      logic         m_any;
      always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) mask[i] = W'(i) <= ptr;
      end
      prio_enc_comb #(.N(N)) u_m (.req(req_i & mask), .idx(m_idx), .any(m_any));
      prio_enc_comb #(.N(N)) u_u (.req(req_i), .idx(u_idx), .any(any));
      assign g = m_any ? m_idx : u_idx;
      always_ff @(posedge clk) begin
        if (rst) ptr <= W'(N - 1);
        else if (load) ptr <= (g == '0) ? W'(N - 1) : g - 1'b1;
      end
    end else begin : g_fx
      prio_enc_comb #(.N(N)) u_f (.req(req_i), .idx(g), .any(any));
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx <= '0;
      out_onehot <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_idx <= g;
      out_onehot <= N'(1) << g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb_prio_encoder_rr: fixed and round-robin encoders checked against a behavioural model
module tb_prio_encoder_rr;
  logic       clk = 0;
  logic       rst = 1;
  logic [7:0] req = 0;
  logic       in_valid = 0;
  logic       out_ready = 0;
  logic       ir [2];
  logic       ov [2];
  logic [2:0] oi [2];
  logic [7:0] oh [2];
  int n_cmp = 0;
  int n_err = 0;
  bit armed = 0;
  bit mv [2];
  bit mhas [2];
  int mi [2];
  int mp [2];

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(8), .RR(0)) dut_f (
    .clk(clk), .rst(rst), .req_i(req), .in_valid(in_valid), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .out_idx(oi[0]), .out_onehot(oh[0]));
  prio_encoder_rr #(.N(8), .RR(1)) dut_r (
    .clk(clk), .rst(rst), .req_i(req), .in_valid(in_valid), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .out_idx(oi[1]), .out_onehot(oh[1]));

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Round-robin search walks downward from the pointer with wraparound; fixed walks down from 7.
  function automatic int pick(int m, logic [7:0] r, int p);
    int i;
    for (int k = 0; k < 8; k++) begin
      i = (m == 1) ? (p - k + 8) % 8 : 7 - k;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mv[m] <= 0; mhas[m] <= 0; mi[m] <= 0; mp[m] <= 7;
      end else begin
        g = pick(m, req, mp[m]);
        if (in_valid && (!mv[m] || out_ready) && g >= 0) begin
          mv[m] <= 1; mhas[m] <= 1; mi[m] <= g;
          if (m == 1) mp[m] <= (g + 7) % 8;
        end else if (out_ready) mv[m] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int m = 0; m < 2; m++) begin
        chk(m ? "rr.out_valid" : "fx.out_valid", int'(ov[m]), int'(mv[m]));
        chk(m ? "rr.in_ready" : "fx.in_ready", int'(ir[m]), int'(!mv[m] || out_ready));
        chk(m ? "rr.out_idx" : "fx.out_idx", int'(oi[m]), mi[m]);
        chk(m ? "rr.out_onehot" : "fx.out_onehot", int'(oh[m]), mhas[m] ? (1 << mi[m]) : 0);
      end
    end
  end

  task automatic step(bit r, bit v, logic [7:0] q, bit ordy);
    rst = r; in_valid = v; req = q; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    armed = 1;
    chk("reset rr.out_valid", int'(ov[1]), 0);
    chk("reset rr.out_idx", int'(oi[1]), 0);
    chk("reset rr.out_onehot", int'(oh[1]), 0);
    step(0, 1, 8'b0010_1100, 1);
    chk("fx 2C valid", int'(ov[0]), 1);
    chk("fx 2C idx", int'(oi[0]), 5);
    chk("fx 2C onehot", int'(oh[0]), 8'h20);
    step(0, 1, 8'h00, 1);
    chk("fx zero valid", int'(ov[0]), 0);
    chk("fx zero in_ready", int'(ir[0]), 1);
    step(0, 1, 8'h01, 1);
    chk("fx 01 idx", int'(oi[0]), 0);
    step(1, 0, 0, 1);
    foreach (oi[k]) begin end
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 8'hFF, 1);
      chk("rr FF seq", int'(oi[1]), 7 - k);
    end
    step(0, 1, 8'h03, 1); chk("rr 03 #1", int'(oi[1]), 1);
    step(0, 1, 8'h03, 1); chk("rr 03 #2", int'(oi[1]), 0);
    step(0, 1, 8'h03, 1); chk("rr 03 #3", int'(oi[1]), 1);
    step(1, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 1, 8'hFF, 1);
    chk("rr pre-reset idx", int'(oi[1]), 3);
    step(1, 0, 0, 0);
    chk("rr mid reset valid", int'(ov[1]), 0);
    chk("rr mid reset idx", int'(oi[1]), 0);
    chk("rr mid reset onehot", int'(oh[1]), 0);
    step(0, 1, 8'hFF, 1);
    chk("rr after reset idx", int'(oi[1]), 7);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 8'(1 << k), 0);
      chk("stall in_ready", int'(ir[1]), 0);
      chk("stall idx held", int'(oi[1]), 7);
      chk("stall onehot held", int'(oh[1]), 8'h80);
    end
    step(0, 0, 8'hFF, 1);
    chk("release drain valid", int'(ov[1]), 0);
    step(0, 1, 8'hFF, 1);
    chk("release ptr once", int'(oi[1]), 6);
    for (int k = 0; k < 8; k++) begin
      q = 8'($urandom_range(1, 255));
      step(0, 1, q, 1);
      chk("stream valid", int'(ov[1]), 1);
      chk("stream in_ready", int'(ir[1]), 1);
    end
    for (int k = 0; k < 3000; k++) begin
      q = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, q, $urandom_range(0, 2) != 0);
    end
    step(0, 0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
